// File: rtl/set24_time_editor_pkg.sv
// -----------------------------------------------------------------------------
// set24_time_editor_pkg
//
// Shared definitions for the 24-hour set-mode time editor and the display
// decoder that consumes its hours/minutes values.
//
// Contents:
//   state_t          - editor FSM encoding (IDLE, EDIT_HOUR, EDIT_MIN, COMMIT)
//   HOUR_W/MINUTE_W  - field widths shared with the display decoder
//   MAX_HOUR/MAX_MINUTE - largest legal value of each field
//   helper functions - range clamp and wrap-around increment/decrement
// -----------------------------------------------------------------------------
package set24_time_editor_pkg;

    localparam int HOUR_W   = 5;
    localparam int MINUTE_W = 6;

    localparam logic [HOUR_W-1:0]   MAX_HOUR   = HOUR_W'(23);
    localparam logic [MINUTE_W-1:0] MAX_MINUTE = MINUTE_W'(59);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EDIT_HOUR = 2'd1,
        EDIT_MIN  = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    // Out-of-range running-clock values are shown and edited as zero.
    function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] h);
        return (h > MAX_HOUR) ? '0 : h;
    endfunction

    function automatic logic [MINUTE_W-1:0] clamp_minute(input logic [MINUTE_W-1:0] m);
        return (m > MAX_MINUTE) ? '0 : m;
    endfunction

    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [HOUR_W-1:0] hour_dec(input logic [HOUR_W-1:0] h);
        return (h == '0 || h > MAX_HOUR) ? MAX_HOUR : h - HOUR_W'(1);
    endfunction

    function automatic logic [MINUTE_W-1:0] minute_inc(input logic [MINUTE_W-1:0] m);
        return (m >= MAX_MINUTE) ? '0 : m + MINUTE_W'(1);
    endfunction

    function automatic logic [MINUTE_W-1:0] minute_dec(input logic [MINUTE_W-1:0] m);
        return (m == '0 || m > MAX_MINUTE) ? MAX_MINUTE : m - MINUTE_W'(1);
    endfunction

endpackage

// File: rtl/set24_time_editor_if.sv
// -----------------------------------------------------------------------------
// set24_time_editor_if
//
// Bundles the editor's button inputs, running-time inputs and edited-time
// outputs.
//
// Signals:
//   btn_mode/btn_up/btn_down - raw asynchronous active-high buttons
//   cur_hours/cur_minutes    - running-clock time, tracked while idle
//   hours/minutes            - value shown and edited
//   editing                  - high in EDIT_HOUR or EDIT_MIN
//   blink_hours/blink_minutes- high in EDIT_HOUR / EDIT_MIN respectively
//   commit                   - load strobe for the running timekeeper
//   state                    - editor FSM state, for observation only
//
// Handshake: commit is a single-cycle strobe with no back-pressure; hours and
// minutes are valid in the same cycle and the timekeeper must take them then.
//
// Modports:
//   master - the environment driving buttons and running time
//   slave  - the editor itself
// -----------------------------------------------------------------------------
interface set24_time_editor_if;
    import set24_time_editor_pkg::*;

    logic                btn_mode;
    logic                btn_up;
    logic                btn_down;
    logic [HOUR_W-1:0]   cur_hours;
    logic [MINUTE_W-1:0] cur_minutes;
    logic [HOUR_W-1:0]   hours;
    logic [MINUTE_W-1:0] minutes;
    logic                editing;
    logic                blink_hours;
    logic                blink_minutes;
    logic                commit;
    state_t              state;

    modport master (
        output btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
        input  hours, minutes, editing, blink_hours, blink_minutes, commit, state
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, cur_hours, cur_minutes,
        output hours, minutes, editing, blink_hours, blink_minutes, commit, state
    );

endinterface

// File: rtl/set24_time_editor_button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Turns one raw asynchronous button into clean, single-cycle events.
//   - 2-flop synchronizer
//   - debounce: the accepted level follows the synchronized input only after
//     it has differed for DEBOUNCE_CYCLES consecutive cycles
//   - press: one cycle on an accepted 0->1 change
//   - repeat_pulse (REPEAT_EN=1 only): HOLD_CYCLES after press, then every
//     REPEAT_CYCLES, while the accepted level stays high
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   btn           - raw button
//   level         - debounced level
//   press         - one-cycle press pulse
//   repeat_pulse  - one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press,
    output logic repeat_pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    logic             sync_ff1;
    logic             sync_ff2;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_phase;   // 0: waiting out the hold, 1: repeating
    logic             differs;
    logic             accept;
    logic [RPT_W-1:0] rpt_last;

    assign differs  = (sync_ff2 != level);
    // The cycle in which the accepted level is about to flip.
    assign accept   = differs && (db_cnt == DB_LAST);
    assign rpt_last = rpt_phase ? REP_LAST : HOLD_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= btn;
            sync_ff2 <= sync_ff1;
        end
    end

    // Any cycle where the synchronized input agrees with the accepted level
    // restarts the count, so a glitch never accumulates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= accept && sync_ff2;
            if (!differs || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (accept) begin
                level <= sync_ff2;
            end
        end
    end

    // Counting only runs while the level is high and not about to drop, so
    // the counter is already zero on the first cycle after a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt      <= '0;
            rpt_phase    <= 1'b0;
            repeat_pulse <= 1'b0;
        end else if (REPEAT_EN && level && !accept) begin
            if (rpt_cnt == rpt_last) begin
                rpt_cnt      <= '0;
                rpt_phase    <= 1'b1;
                repeat_pulse <= 1'b1;
            end else begin
                rpt_cnt      <= rpt_cnt + RPT_W'(1);
                repeat_pulse <= 1'b0;
            end
        end else begin
            rpt_cnt      <= '0;
            rpt_phase    <= 1'b0;
            repeat_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/set24_time_editor.sv
// -----------------------------------------------------------------------------
// set24_time_editor
//
// Button-driven 24-hour time editor. While idle the outputs track the running
// clock; the mode button walks IDLE -> EDIT_HOUR -> EDIT_MIN -> COMMIT, up and
// down step the field being edited with wrap-around (auto-repeat when held),
// and COMMIT emits a one-cycle load strobe. An edit left untouched for
// TIMEOUT_CYCLES is abandoned without committing.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - set24_time_editor_if.slave: buttons, running time, edited time,
//            status flags, commit strobe and FSM state
// -----------------------------------------------------------------------------
module set24_time_editor
    import set24_time_editor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    set24_time_editor_if.slave    bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic mode_level, mode_press, mode_repeat;
    logic up_level,   up_press,   up_repeat;
    logic down_level, down_press, down_repeat;
    logic up_step, down_step, any_step;
    logic unused_cond;

    state_t              state;
    logic [HOUR_W-1:0]   hours_q;
    logic [MINUTE_W-1:0] minutes_q;
    logic                editing_q;
    logic                blink_hours_q;
    logic                blink_minutes_q;
    logic                commit_q;
    logic [TO_W-1:0]     to_cnt;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_mode (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (bus.btn_mode),
        .level        (mode_level),
        .press        (mode_press),
        .repeat_pulse (mode_repeat)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b1)
    ) u_up (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (bus.btn_up),
        .level        (up_level),
        .press        (up_press),
        .repeat_pulse (up_repeat)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b1)
    ) u_down (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (bus.btn_down),
        .level        (down_level),
        .press        (down_press),
        .repeat_pulse (down_repeat)
    );

    // Levels and the mode repeat output are not needed by the editor.
    assign unused_cond = ^{mode_level, mode_repeat, up_level, down_level};

    assign up_step   = up_press | up_repeat;
    assign down_step = down_press | down_repeat;
    assign any_step  = up_step | down_step;

    // Within each edit state the priority is: mode press, then up/down step
    // (opposing steps cancel but still count as activity), then timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hours_q         <= '0;
            minutes_q       <= '0;
            editing_q       <= 1'b0;
            blink_hours_q   <= 1'b0;
            blink_minutes_q <= 1'b0;
            commit_q        <= 1'b0;
            to_cnt          <= '0;
        end else begin
            commit_q <= 1'b0;
            case (state)
                IDLE: begin
                    hours_q   <= clamp_hour(bus.cur_hours);
                    minutes_q <= clamp_minute(bus.cur_minutes);
                    to_cnt    <= '0;
                    if (mode_press) begin
                        state         <= EDIT_HOUR;
                        editing_q     <= 1'b1;
                        blink_hours_q <= 1'b1;
                    end
                end

                EDIT_HOUR: begin
                    if (mode_press) begin
                        state           <= EDIT_MIN;
                        blink_hours_q   <= 1'b0;
                        blink_minutes_q <= 1'b1;
                        to_cnt          <= '0;
                    end else if (any_step) begin
                        to_cnt <= '0;
                        if (up_step && !down_step) begin
                            hours_q <= hour_inc(hours_q);
                        end else if (down_step && !up_step) begin
                            hours_q <= hour_dec(hours_q);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state         <= IDLE;
                        editing_q     <= 1'b0;
                        blink_hours_q <= 1'b0;
                        to_cnt        <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                EDIT_MIN: begin
                    if (mode_press) begin
                        state           <= COMMIT;
                        editing_q       <= 1'b0;
                        blink_minutes_q <= 1'b0;
                        commit_q        <= 1'b1;
                        to_cnt          <= '0;
                    end else if (any_step) begin
                        to_cnt <= '0;
                        if (up_step && !down_step) begin
                            minutes_q <= minute_inc(minutes_q);
                        end else if (down_step && !up_step) begin
                            minutes_q <= minute_dec(minutes_q);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state           <= IDLE;
                        editing_q       <= 1'b0;
                        blink_minutes_q <= 1'b0;
                        to_cnt          <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                COMMIT: begin
                    // commit_q drops via the default above; values hold.
                    state  <= IDLE;
                    to_cnt <= '0;
                end

                default: begin
                    state           <= IDLE;
                    editing_q       <= 1'b0;
                    blink_hours_q   <= 1'b0;
                    blink_minutes_q <= 1'b0;
                    to_cnt          <= '0;
                end
            endcase
        end
    end

    assign bus.hours         = hours_q;
    assign bus.minutes       = minutes_q;
    assign bus.editing       = editing_q;
    assign bus.blink_hours   = blink_hours_q;
    assign bus.blink_minutes = blink_minutes_q;
    assign bus.commit        = commit_q;
    assign bus.state         = state;

endmodule

// File: tb/tb_set24_time_editor.sv
// -----------------------------------------------------------------------------
// tb_set24_time_editor
//
// Self-checking bench for set24_time_editor with short debounce/hold/repeat/
// timeout values. Every edit-value change and every commit strobe the DUT
// produces is popped from an expected queue filled as stimulus is applied;
// direct checks cover reset, idle tracking, timing and status flags.
// -----------------------------------------------------------------------------
module tb_set24_time_editor;
    import set24_time_editor_pkg::*;

    localparam int SB_W = 1 + HOUR_W + MINUTE_W;
    localparam int B_MODE = 1;
    localparam int B_UP   = 2;
    localparam int B_DOWN = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    set24_time_editor_if bus();

    set24_time_editor #(
        .DEBOUNCE_CYCLES (2),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks       = 0;
    int errors       = 0;
    int commits_seen = 0;
    int exp_commits  = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input logic is_commit, input int h, input int m);
        exp_q.push_back({is_commit, HOUR_W'(h), MINUTE_W'(m)});
        if (is_commit) exp_commits++;
    endtask

    task automatic sb_compare(input string tag, input logic [SB_W-1:0] obs);
        logic [SB_W-1:0] exp;
        check_val({tag, "_pending"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_val(tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Hold the selected buttons for high_cycles, then release long enough
    // for the release to be debounced.
    task automatic press(input int mask, input int high_cycles);
        bus.btn_mode = mask[0];
        bus.btn_up   = mask[1];
        bus.btn_down = mask[2];
        tick(high_cycles);
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(8);
    endtask

    task automatic set_cur(input int h, input int m);
        bus.cur_hours   = HOUR_W'(h);
        bus.cur_minutes = MINUTE_W'(m);
    endtask

    // ---------------- monitor ----------------
    logic                prev_editing = 1'b0;
    logic                prev_commit  = 1'b0;
    logic [HOUR_W-1:0]   prev_h       = '0;
    logic [MINUTE_W-1:0] prev_m       = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_editing = 1'b0;
            prev_commit  = 1'b0;
            prev_h       = '0;
            prev_m       = '0;
        end else begin
            if (bus.commit) begin
                commits_seen++;
                check_val("commit_width", prev_commit, 0);
                sb_compare("commit_val", {1'b1, bus.hours, bus.minutes});
            end else if (bus.editing &&
                         (!prev_editing || bus.hours != prev_h || bus.minutes != prev_m)) begin
                sb_compare("edit_val", {1'b0, bus.hours, bus.minutes});
            end
            prev_editing = bus.editing;
            prev_commit  = bus.commit;
            prev_h       = bus.hours;
            prev_m       = bus.minutes;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        set_cur(13, 45);

        // 1. reset values, idle tracking, asynchronous reset
        tick(2);
        check_val("rst_hours",   bus.hours, 0);
        check_val("rst_minutes", bus.minutes, 0);
        check_val("rst_editing", bus.editing, 0);
        check_val("rst_commit",  bus.commit, 0);
        check_val("rst_state",   bus.state, IDLE);
        rst_n = 1'b1;
        tick(3);
        check_val("idle_hours",   bus.hours, 13);
        check_val("idle_minutes", bus.minutes, 45);
        check_val("idle_editing", bus.editing, 0);
        check_val("idle_commit",  bus.commit, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_hours",   bus.hours, 0);
        check_val("arst_minutes", bus.minutes, 0);
        check_val("arst_editing", bus.editing, 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);

        // 2. wrap 23->0 and 59->0, then commit 00:00
        set_cur(23, 59);
        tick(2);
        sb_push(1'b0, 23, 59);
        press(B_MODE, 6);
        check_val("eh_state",  bus.state, EDIT_HOUR);
        check_val("eh_blink_h", bus.blink_hours, 1);
        check_val("eh_blink_m", bus.blink_minutes, 0);
        check_val("eh_editing", bus.editing, 1);
        sb_push(1'b0, 0, 59);
        press(B_UP, 6);
        press(B_MODE, 6);
        check_val("em_state",   bus.state, EDIT_MIN);
        check_val("em_blink_h", bus.blink_hours, 0);
        check_val("em_blink_m", bus.blink_minutes, 1);
        sb_push(1'b0, 0, 0);
        press(B_UP, 6);
        sb_push(1'b1, 0, 0);
        press(B_MODE, 6);
        check_val("t2_state",   bus.state, IDLE);
        check_val("t2_editing", bus.editing, 0);
        check_val("t2_hours",   bus.hours, 23);
        check_val("t2_minutes", bus.minutes, 59);

        // 3. 0 -> 23 on down, bounce ignored, up+down cancel
        set_cur(0, 30);
        tick(2);
        sb_push(1'b0, 0, 30);
        press(B_MODE, 6);
        sb_push(1'b0, 23, 30);
        press(B_DOWN, 6);
        press(B_UP, 1);
        check_val("bounce_hours", bus.hours, 23);
        press(B_UP | B_DOWN, 6);
        check_val("updown_hours", bus.hours, 23);
        check_val("t3_state",     bus.state, EDIT_HOUR);
        press(B_MODE, 6);
        sb_push(1'b1, 23, 30);
        press(B_MODE, 6);

        // 4. auto-repeat in EDIT_MIN. The accepted level lags the raw button
        // by the debounce latency, so a 26-cycle raw hold keeps it high
        // through the repeat at cycle 28 and drops it before cycle 32:
        // press at 4, repeats at 12/16/20/24/28 -> 10 + 6 = 16.
        set_cur(5, 10);
        tick(2);
        sb_push(1'b0, 5, 10);
        press(B_MODE, 6);
        press(B_MODE, 6);
        for (int v = 11; v <= 16; v++) sb_push(1'b0, 5, v);
        bus.btn_up = 1'b1;
        for (int t = 1; t <= 26; t++) begin
            tick(1);
            if (t == 4)  check_val("rpt_before_press", bus.minutes, 10);
            if (t == 5)  check_val("rpt_after_press",  bus.minutes, 11);
            if (t == 12) check_val("rpt_before_first", bus.minutes, 11);
            if (t == 13) check_val("rpt_after_first",  bus.minutes, 12);
            if (t == 17) check_val("rpt_after_second", bus.minutes, 13);
        end
        bus.btn_up = 1'b0;
        tick(10);
        check_val("rpt_final", bus.minutes, 16);
        sb_push(1'b1, 5, 16);
        press(B_MODE, 6);

        // 5. timeout abandons the edit without commit
        set_cur(7, 20);
        tick(2);
        sb_push(1'b0, 7, 20);
        press(B_MODE, 6);
        sb_push(1'b0, 8, 20);
        press(B_UP, 6);
        tick(40);
        check_val("to_still_editing", bus.editing, 1);
        tick(20);
        check_val("to_editing", bus.editing, 0);
        check_val("to_state",   bus.state, IDLE);
        check_val("to_hours",   bus.hours, 7);
        check_val("to_commits", commits_seen, exp_commits);
        set_cur(9, 20);
        tick(2);
        check_val("to_track", bus.hours, 9);

        // 6. out-of-range running time loads 0:00; mode beats up
        set_cur(30, 62);
        tick(2);
        check_val("oor_idle_h", bus.hours, 0);
        check_val("oor_idle_m", bus.minutes, 0);
        sb_push(1'b0, 0, 0);
        press(B_MODE, 6);
        check_val("oor_state", bus.state, EDIT_HOUR);
        press(B_MODE | B_UP, 6);
        check_val("modewin_state", bus.state, EDIT_MIN);
        check_val("modewin_hours", bus.hours, 0);
        sb_push(1'b0, 0, 1);
        press(B_UP, 6);
        sb_push(1'b1, 0, 1);
        press(B_MODE, 6);
        tick(4);
        check_val("t6_state", bus.state, IDLE);

        check_val("sb_drained", exp_q.size(), 0);
        check_val("commit_count", commits_seen, exp_commits);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
